// File: rtl/led_fade_driver.sv
// led_fade_driver: three-lamp PWM driver that turns on/off requests into brightness ramps.
// Target and PWM drive are registered; each level moves RAMP_STEP once every RAMP_DIV enabled cycles.
module led_fade_driver #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_DIV  = 4,
  parameter int RAMP_STEP = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            led_in,
  input  logic                  enable,
  output logic [2:0]            pwm_out,
  output logic [3*PWM_BITS-1:0] level,
  output logic [2:0]            busy
);

  localparam int                  CNT_W    = $clog2(RAMP_DIV);
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS:0]   STEP     = (PWM_BITS + 1)'(RAMP_STEP);

  logic [2:0]          target;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [CNT_W-1:0]    ramp_cnt;
  logic                ramp_tick;

  assign ramp_tick = enable && (ramp_cnt == DIV_LAST);

  // ramp_cnt holds its phase while disabled so a resumed ramp keeps its cadence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target   <= '0;
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
    end else begin
      target  <= led_in;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (enable) begin
        ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [PWM_BITS-1:0] lvl_q;
    logic [PWM_BITS-1:0] lvl_nxt;
    logic [PWM_BITS-1:0] tgt_val;
    logic [PWM_BITS:0]   sum;
    logic [PWM_BITS:0]   diff;
    logic                pwm_q;

    assign tgt_val = target[i] ? MAX : '0;
    assign sum     = {1'b0, lvl_q} + STEP;
    // the extra MSB acts as the borrow, so underflow is seen before truncation
    assign diff    = {1'b0, lvl_q} - STEP;

    always_comb begin
      lvl_nxt = lvl_q;
      if (lvl_q < tgt_val) begin
        lvl_nxt = sum[PWM_BITS] ? MAX : sum[PWM_BITS-1:0];
      end else if (lvl_q > tgt_val) begin
        lvl_nxt = diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lvl_q <= '0;
        pwm_q <= 1'b0;
      end else begin
        if (ramp_tick) begin
          lvl_q <= lvl_nxt;
        end
        pwm_q <= (lvl_q == MAX) || (lvl_q > pwm_cnt);
      end
    end

    assign level[i*PWM_BITS +: PWM_BITS] = lvl_q;
    assign busy[i]                        = (lvl_q != tgt_val);
    assign pwm_out[i]                     = pwm_q;
  end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Downstream stage of the three-lamp pattern sequencer (bar, mosca, azul). It consumes the sequencer's 3-bit lamp word and drives the physical lamps through per-channel PWM with soft fade-in and fade-out. A requested on/off state becomes a brightness ramp toward full or zero, so lamps never snap.

## Interface
- PWM_BITS, 8, width of brightness level and PWM counter; MAX = 2^PWM_BITS-1
- RAMP_DIV, 4, clock cycles per ramp step (>=2)
- RAMP_STEP, 32, brightness change per ramp step (1..MAX)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- led_in  in  3  requested lamp state from the sequencer; bit2=bar, bit1=mosca, bit0=azul
- enable  in  1  1 = ramps advance; 0 = levels frozen, PWM keeps running
- pwm_out  out  3  PWM lamp drive, same bit order as led_in
- level  out  3*PWM_BITS  current brightness; channel i at level[i*PWM_BITS +: PWM_BITS]
- busy  out  3  busy[i]=1 while level[i] differs from its target

## Operation
- Reset (async, any time, including mid-ramp): pwm_cnt=0, ramp_cnt=0, target=0, all levels=0, pwm_out=0. busy therefore reads 0.
- target[i] <= led_in[i] every edge. This is a one-cycle input register. Target value is MAX when 1 and 0 when 0.
- pwm_cnt: PWM_BITS wide, +1 every edge, wraps MAX->0. Unaffected by enable.
- ramp_cnt counts 0..RAMP_DIV-1 and wraps. It advances only when enable=1 and holds its value when enable=0.
- ramp_tick = enable && ramp_cnt==RAMP_DIV-1 (combinational).
- On an edge with ramp_tick=1, each channel updates independently:
  - level<tgt: level = min(level+RAMP_STEP, MAX). Sum computed in PWM_BITS+1 bits, then saturated.
  - level>tgt: level = max(level-RAMP_STEP, 0). Underflow is detected before truncation and clamps to 0.
  - level==tgt: hold.
- Direction reversal mid-ramp continues from the current level. The ramp is never restarted or re-phased.
- pwm_out[i] <= (level[i]==MAX) || (level[i] > pwm_cnt). The output is registered, so full brightness is a constant 1, level 0 is a constant 0, and level L gives L high cycles per 256-cycle period (N=8).
- busy[i] = (level[i] != target value), combinational from registers.

## Timing
- Reset released before edge 1, led_in stable: target valid after edge 1. ramp_cnt reads 1,2,3 after edges 1-3, so level updates occur on edges 4, 8, 12, … (every RAMP_DIV edges).
- A led_in change is seen by target on the next edge. It affects level at the first ramp edge after that, so latency is 1..RAMP_DIV+1 cycles.
- Full swing 0->MAX with defaults: 32,64,…,224,255, i.e. 8 steps = 32 cycles. The last step saturates 256->255.
- pwm_out lags level and pwm_cnt by one cycle.
- enable low: no level change on any edge. When enable returns high, ramp_cnt resumes from its held value; it is not reset.
- A simultaneous led_in change and ramp_tick uses the old target for that tick.

## Test plan
- Reset, led_in=3'b100 held from edge 0, enable=1:
  - Required: level[2] = 32 after edge 4, 64 after edge 8, … 224 after edge 28, 255 after edge 32.
  - Required: busy=3'b100 from edge 1 through edge 31, then 3'b000.
  - Required: levels 1 and 0 stay at 0.
- After full-on, hold 512 cycles -> pwm_out[2] constant 1. Then led_in=0 -> level[2] steps 223,191,…,31,0 (8 steps) -> pwm_out[2] constant 0.
- Reversal: start rising, set led_in=0 once level[2]=96 -> next ramp edges give 64, 32, 0. The level never rises above 96.
- Duty: ramp level[1] to 96, then enable=0 -> level frozen at 96. Over any 256 consecutive cycles, pwm_out[1] is high exactly 96 cycles.
- Assert reset asynchronously (between clock edges) mid-ramp with level 160 -> all outputs are 0 before the next edge. After release, the ramp restarts from 0.
- Saturation with RAMP_STEP=100 -> rising sequence 100, 200, 255 and falling sequence 155, 55, 0.
